// File: rtl/nibble_sender_pkg.sv
// nibble_sender_pkg: shared types and constants for the nibble sender.
//   state_t     - sequencer states
//   NUM_NIBBLES - nibbles per transferred word
//   NIB_W       - bits per nibble
package nibble_sender_pkg;

  localparam int NUM_NIBBLES = 4;
  localparam int NIB_W       = 4;
  localparam int WORD_W      = NUM_NIBBLES * NIB_W;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    GAP,
    RD_LO,
    RD_HI,
    FIN
  } state_t;

endpackage

// File: rtl/nibble_phase_timer.sv
// nibble_phase_timer: down-counter pacing each sequencer phase.
//   clk      - clock
//   reset    - asynchronous active-low reset, clears the count
//   load     - load strobe, takes priority over counting
//   load_val - phase length minus one
//   expired  - high while the count sits at zero
// A phase loaded with N-1 expires in its N-th cycle.
module nibble_phase_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/nibble_sender.sv
// nibble_sender: sends a 16-bit word to the multiplier tile one nibble at a
// time (MSB nibble first), pacing nib_valid slow enough for the tile's
// debouncer. Optional product readback is enabled by defining the macro
// NIBBLE_SENDER_READBACK_EN.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   start, word_in    - host request and word (sampled in IDLE only)
//   busy, done        - sequence in progress / one-cycle completion pulse
//   nib_data          - nibble on the tile data pins
//   nib_valid         - tile valid pin (registered, glitch-free)
//   rd_toggle         - tile byte select, 0 = low byte (readback only)
//   res_in            - tile io_out (readback only)
//   result            - captured product (readback only, else 0)
//   result_valid      - pulses with done on capture (readback only, else 0)
//
// state | meaning
// IDLE  | waiting for start
// HOLD  | nib_valid high for HOLD_CYCLES
// GAP   | nib_valid low for GAP_CYCLES, same nibble still on nib_data
// RD_LO | rd_toggle=0 settling, then capture low product byte
// RD_HI | rd_toggle=1 settling, then capture high product byte
// FIN   | done pulse, back to IDLE
module nibble_sender
  import nibble_sender_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2048,
  parameter int GAP_CYCLES    = 2048,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  output logic              busy,
  output logic              done,
  output logic [NIB_W-1:0]  nib_data,
  output logic              nib_valid,
  output logic              rd_toggle,
  input  logic [7:0]        res_in,
  output logic [15:0]       result,
  output logic              result_valid
);

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST_NIB    = 2'(NUM_NIBBLES - 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_expired;
  logic              valid_q, busy_q, done_q;

`ifdef NIBBLE_SENDER_READBACK_EN
  logic        cap_lo, cap_hi;
  logic        toggle_q, rvalid_q;
  logic [15:0] result_q;
`endif

  nibble_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef NIBBLE_SENDER_READBACK_EN
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = word_in;
          cnt_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (tmr_expired) begin
          if (cnt_q != LAST_NIB) begin
            // next nibble appears together with the rising valid edge
            shift_d  = {shift_q[WORD_W-NIB_W-1:0], {NIB_W{1'b0}}};
            cnt_d    = cnt_q + 2'd1;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
            state_d  = HOLD;
          end else begin
`ifdef NIBBLE_SENDER_READBACK_EN
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
            state_d  = RD_LO;
`else
            state_d  = FIN;
`endif
          end
        end
      end
`ifdef NIBBLE_SENDER_READBACK_EN
      RD_LO: begin
        if (tmr_expired) begin
          cap_lo   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
          state_d  = RD_HI;
        end
      end
      RD_HI: begin
        if (tmr_expired) begin
          cap_hi  = 1'b1;
          state_d = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so nib_valid and friends
  // change cleanly on the same edge as the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == HOLD);
      busy_q  <= (state_d == HOLD) || (state_d == GAP) ||
                 (state_d == RD_LO) || (state_d == RD_HI);
      done_q  <= (state_d == FIN);
    end
  end

  assign nib_data  = shift_q[WORD_W-1 -: NIB_W];
  assign nib_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef NIBBLE_SENDER_READBACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
      rvalid_q <= 1'b0;
      result_q <= '0;
    end else begin
      toggle_q <= (state_d == RD_HI);
      rvalid_q <= (state_d == FIN);
      if (cap_lo) result_q[7:0]  <= res_in;
      if (cap_hi) result_q[15:8] <= res_in;
    end
  end

  assign rd_toggle    = toggle_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;
`else
  logic unused_readback;
  assign unused_readback = ^{res_in, SETTLE_LOAD};

  assign rd_toggle    = 1'b0;
  assign result       = '0;
  assign result_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_sender.sv
// tb_nibble_sender: directed bench for nibble_sender with H=4, G=3, S=2.
// Define NIBBLE_SENDER_READBACK_EN to include the product readback checks.
module tb_nibble_sender;

  localparam int H = 4;
  localparam int G = 3;
  localparam int S = 2;
`ifdef NIBBLE_SENDER_READBACK_EN
  localparam int EXTRA = 2 * S;
`else
  localparam int EXTRA = 0;
`endif
  // last busy cycle of a sequence whose start is accepted at edge 0
  localparam int LAST = 4 * (H + G) + EXTRA;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word_in = '0;
  logic        busy, done, nib_valid, rd_toggle, result_valid;
  logic [3:0]  nib_data;
  logic [7:0]  res_in;
  logic [15:0] result;

  nibble_sender #(
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G),
    .SETTLE_CYCLES (S),
    .CNT_W         (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .word_in      (word_in),
    .busy         (busy),
    .done         (done),
    .nib_data     (nib_data),
    .nib_valid    (nib_valid),
    .rd_toggle    (rd_toggle),
    .res_in       (res_in),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // behavioural tile: shifts a nibble in on each valid rising edge,
  // multiplies the two bytes and returns the byte chosen by rd_toggle
  logic [15:0] tile_sh;
  logic        tile_pv;
  logic [15:0] tile_prod;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_sh <= '0;
      tile_pv <= 1'b0;
    end else begin
      tile_pv <= nib_valid;
      if (nib_valid && !tile_pv) tile_sh <= {tile_sh[11:0], nib_data};
    end
  end
  always_comb begin
    tile_prod = 16'(tile_sh[15:8]) * 16'(tile_sh[7:0]);
    res_in    = rd_toggle ? tile_prod[15:8] : tile_prod[7:0];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int rises, done_cnt, bad_nib;
  int rise_cyc [8];
  int rise_nib [8];
  int done_cyc [2];

  typedef struct {
    int cyc;
    int valid;
    int busy;
    int done;
    int nib;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  // Runs n cycles from cyc=0 (start asserted in cycle 0), logging valid
  // rising edges, the nibble present at each, done pulses, and any
  // nib_data change that is not on a valid rising edge.
  task automatic observe(input int n, input bit keep, input int poke_cyc,
                         input logic [15:0] poke_word);
    logic pv;
    logic [3:0] pn;
    rises = 0; done_cnt = 0; bad_nib = 0;
    pv = nib_valid; pn = nib_data;
    for (int i = 0; i < n; i++) begin
      if (cyc == 0 || keep) start = 1'b1;
      else if (cyc == poke_cyc) begin
        start = 1'b1;
        word_in = poke_word;
      end else start = 1'b0;
      tick();
      if (nib_valid && !pv) begin
        if (rises < 8) begin
          rise_cyc[rises] = cyc;
          rise_nib[rises] = int'(nib_data);
        end
        rises++;
      end else if (nib_data !== pn) begin
        bad_nib++;
      end
      if (done) begin
        if (done_cnt < 2) done_cyc[done_cnt] = cyc;
        done_cnt++;
      end
      pv = nib_valid;
      pn = nib_data;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,        1, 1, 0, 'h3};
    tbl[1]  = '{4,        1, 1, 0, 'h3};
    tbl[2]  = '{5,        0, 1, 0, 'h3};
    tbl[3]  = '{7,        0, 1, 0, 'h3};
    tbl[4]  = '{8,        1, 1, 0, 'hA};
    tbl[5]  = '{11,       1, 1, 0, 'hA};
    tbl[6]  = '{12,       0, 1, 0, 'hA};
    tbl[7]  = '{15,       1, 1, 0, 'h5};
    tbl[8]  = '{18,       1, 1, 0, 'h5};
    tbl[9]  = '{21,       0, 1, 0, 'h5};
    tbl[10] = '{22,       1, 1, 0, 'hC};
    tbl[11] = '{25,       1, 1, 0, 'hC};
    tbl[12] = '{28,       0, 1, 0, 'hC};
    tbl[13] = '{LAST + 1, 0, 0, 1, 'hC};
    tbl[14] = '{LAST + 2, 0, 0, 0, 'hC};

    // reset values
    #1;
    check("rst nib_valid", int'(nib_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst nib_data", int'(nib_data), 0);
    check("rst rd_toggle", int'(rd_toggle), 0);
    check("rst result", int'(result), 0);
    check("rst result_valid", int'(result_valid), 0);
    do_reset();

    // 1: 0x3A5C, table-driven timing
    word_in = 16'h3A5C;
    start = 1'b1;
    for (int e = 0; e < 15; e++) begin
      while (cyc < tbl[e].cyc) begin
        tick();
        start = 1'b0;
      end
      check($sformatf("t1 c%0d valid", cyc), int'(nib_valid), tbl[e].valid);
      check($sformatf("t1 c%0d busy", cyc), int'(busy), tbl[e].busy);
      check($sformatf("t1 c%0d done", cyc), int'(done), tbl[e].done);
      check($sformatf("t1 c%0d nib", cyc), int'(nib_data), tbl[e].nib);
    end
`ifndef NIBBLE_SENDER_READBACK_EN
    check("t1 rd_toggle tied", int'(rd_toggle), 0);
    check("t1 result tied", int'(result), 0);
    check("t1 result_valid tied", int'(result_valid), 0);
`endif

    // 2: start during transfer is ignored
    do_reset();
    word_in = 16'h1234;
    observe(LAST + 3, 1'b0, 10, 16'hFFFF);
    check("t2 rises", rises, 4);
    check("t2 nib0", rise_nib[0], 'h1);
    check("t2 nib1", rise_nib[1], 'h2);
    check("t2 nib2", rise_nib[2], 'h3);
    check("t2 nib3", rise_nib[3], 'h4);
    check("t2 done count", done_cnt, 1);
    check("t2 done cycle", done_cyc[0], LAST + 1);

    // 3: async reset in the second HOLD, then a clean sequence
    do_reset();
    word_in = 16'h5678;
    observe(9, 1'b0, -1, 16'h0);
    check("t3 valid before reset", int'(nib_valid), 1);
    check("t3 nib before reset", int'(nib_data), 'h6);
    reset = 1'b0;
    #1;
    check("t3 abort valid", int'(nib_valid), 0);
    check("t3 abort busy", int'(busy), 0);
    check("t3 abort done", int'(done), 0);
    check("t3 abort nib", int'(nib_data), 0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    word_in = 16'h00F0;
    observe(LAST + 2, 1'b0, -1, 16'h0);
    check("t3 rises", rises, 4);
    check("t3 nib0", rise_nib[0], 'h0);
    check("t3 nib1", rise_nib[1], 'h0);
    check("t3 nib2", rise_nib[2], 'hF);
    check("t3 nib3", rise_nib[3], 'h0);
    check("t3 first rise", rise_cyc[0], 1);
    check("t3 done cycle", done_cyc[0], LAST + 1);

    // 4: start held high, back-to-back sequences
    do_reset();
    word_in = 16'hBEEF;
    observe(2 * LAST + 3, 1'b1, -1, 16'h0);
    check("t4 rises", rises, 8);
    check("t4 done count", done_cnt, 2);
    check("t4 done0", done_cyc[0], LAST + 1);
    check("t4 done1", done_cyc[1], 2 * LAST + 3);
    check("t4 second rise", rise_cyc[4], LAST + 3);
    check("t4 nib4", rise_nib[4], 'hB);
    check("t4 nib7", rise_nib[7], 'hF);
    check("t4 nib stable", bad_nib, 0);

    // 6: all-zero and all-one words
    do_reset();
    word_in = 16'h0000;
    observe(LAST + 2, 1'b0, -1, 16'h0);
    check("t6 zero rises", rises, 4);
    check("t6 zero nib stable", bad_nib, 0);
    check("t6 zero done", done_cnt, 1);
    cyc = 0;
    word_in = 16'hFFFF;
    observe(LAST + 2, 1'b0, -1, 16'h0);
    check("t6 ones rises", rises, 4);
    check("t6 ones nib stable", bad_nib, 0);
    check("t6 ones nib3", rise_nib[3], 'hF);
    check("t6 ones done", done_cnt, 1);

`ifdef NIBBLE_SENDER_READBACK_EN
    // 5: readback of 0x0D * 0x0C from the tile model
    do_reset();
    word_in = 16'h0D0C;
    start = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick();
      start = 1'b0;
      if (cyc == 29 || cyc == 30) begin
        check($sformatf("t5 c%0d toggle", cyc), int'(rd_toggle), 0);
        check($sformatf("t5 c%0d busy", cyc), int'(busy), 1);
      end
      if (cyc == 31 || cyc == 32)
        check($sformatf("t5 c%0d toggle", cyc), int'(rd_toggle), 1);
      if (cyc == 33) begin
        check("t5 done", int'(done), 1);
        check("t5 result_valid", int'(result_valid), 1);
        check("t5 result", int'(result), 'h009C);
        check("t5 toggle back", int'(rd_toggle), 0);
      end
      if (cyc == 34) begin
        check("t5 result held", int'(result), 'h009C);
        check("t5 result_valid drop", int'(result_valid), 0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
